// File: rtl/conv_quant_pe_pkg.sv
// Shared width formulas and saturation-range helpers for the conv PE family
// (conv_quant_pe, requant_sat, and downstream maxpool/quantiser consumers).
package conv_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned prod_w(input int unsigned data_w, input int unsigned wgt_w);
    return data_w + wgt_w + 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned wgt_w,
                                        input int unsigned taps);
    return data_w + wgt_w + 1 + clog2(taps);
  endfunction

  function automatic int unsigned bias_stage_w(input int unsigned acc, input int unsigned bias);
    return ((acc > bias) ? acc : bias) + 1;
  endfunction

  // Upper clip bound: unsigned full range with ReLU, signed max otherwise.
  function automatic longint sat_hi(input int unsigned out_w, input logic relu);
    return relu ? ((longint'(1) <<< out_w) - 1) : ((longint'(1) <<< (out_w - 1)) - 1);
  endfunction

  function automatic longint sat_lo(input int unsigned out_w, input logic relu);
    return relu ? longint'(0) : -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/conv_quant_pe_requant_sat.sv
// Combinational requantiser: scale multiply, round half toward +inf, shift,
// then clip to the signed or ReLU-unsigned output range with a sat flag.
module requant_sat
  import conv_pkg::*;
#(
  parameter int unsigned BW      = 25,
  parameter int unsigned SCALE_W = 32,
  parameter int unsigned SHIFT   = 32,
  parameter int unsigned OUT_W   = 8
) (
  input  logic signed [BW-1:0]      b,
  input  logic        [SCALE_W-1:0] scale,
  input  logic                      relu,
  output logic        [OUT_W-1:0]   q,
  output logic                      sat
);

  localparam int unsigned MW = BW + SCALE_W + 1;
  localparam int unsigned RW = MW + 1;

  localparam logic signed [RW-1:0] RND  = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] HI_U = RW'(sat_hi(OUT_W, 1'b1));
  localparam logic signed [RW-1:0] LO_U = RW'(sat_lo(OUT_W, 1'b1));
  localparam logic signed [RW-1:0] HI_S = RW'(sat_hi(OUT_W, 1'b0));
  localparam logic signed [RW-1:0] LO_S = RW'(sat_lo(OUT_W, 1'b0));

  logic signed [MW-1:0] m;
  logic signed [RW-1:0] r;
  logic signed [RW-1:0] hi;
  logic signed [RW-1:0] lo;

  always_comb begin
    m  = MW'(b) * MW'($signed({1'b0, scale}));
    // One guard bit above the product keeps the rounding add from wrapping.
    r  = (RW'(m) + RND) >>> SHIFT;
    hi = relu ? HI_U : HI_S;
    lo = relu ? LO_U : LO_S;
    q   = r[OUT_W-1:0];
    sat = 1'b0;
    if (r > hi) begin
      q   = hi[OUT_W-1:0];
      sat = 1'b1;
    end else if (r < lo) begin
      q   = lo[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/conv_quant_pe.sv
// Pipelined convolution PE: per-tap products, registered adder tree, bias/ReLU,
// requantisation and saturation behind a valid/ready stream with global stall.
module conv_quant_pe
  import conv_pkg::*;
#(
  parameter int unsigned TAPS    = 9,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned WGT_W   = 8,
  parameter int unsigned BIAS_W  = 24,
  parameter int unsigned SCALE_W = 32,
  parameter int unsigned SHIFT   = 32,
  parameter int unsigned OUT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAPS*DATA_W-1:0]   in_data,
  input  logic [TAPS*WGT_W-1:0]    in_wgt,
  input  logic [BIAS_W-1:0]        in_bias,
  input  logic [SCALE_W-1:0]       in_scale,
  input  logic                     in_relu,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat
);

  localparam int unsigned T     = clog2(TAPS);
  localparam int unsigned NPAD  = 1 << T;
  localparam int unsigned PW    = prod_w(DATA_W, WGT_W);
  localparam int unsigned ACC_W = acc_w(DATA_W, WGT_W, TAPS);
  localparam int unsigned BW    = bias_stage_w(ACC_W, BIAS_W);

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en && rst_n;

  logic signed [PW-1:0] prod [TAPS];

  // Heap-ordered tree: leaves NPAD..2*NPAD-1 hold products (zero padded),
  // node i sums nodes 2i and 2i+1, so each depth is one register stage.
  logic signed [ACC_W-1:0] node [1:2*NPAD-1];
  logic        [T:0]       vld;

  logic signed [BIAS_W-1:0]  sb [0:T];
  logic        [SCALE_W-1:0] ss [0:T];
  logic                      sr [0:T];

  logic signed [BW-1:0]      bsum;
  logic signed [BW-1:0]      b_q;
  logic        [SCALE_W-1:0] b_scale;
  logic                      b_relu;
  logic                      b_vld;

  logic [OUT_W-1:0] rq_q;
  logic             rq_sat;

  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      prod[k] = PW'($signed({1'b0, in_data[k*DATA_W +: DATA_W]}))
              * PW'($signed(in_wgt[k*WGT_W +: WGT_W]));
    end
  end

  always_comb begin
    bsum = BW'(node[1]) + BW'(sb[T]);
    if (sr[T] && bsum[BW-1]) bsum = '0;
  end

  requant_sat #(
    .BW      (BW),
    .SCALE_W (SCALE_W),
    .SHIFT   (SHIFT),
    .OUT_W   (OUT_W)
  ) u_requant_sat (
    .b     (b_q),
    .scale (b_scale),
    .relu  (b_relu),
    .q     (rq_q),
    .sat   (rq_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < 2 * NPAD; i++) node[i] <= '0;
      for (int unsigned s = 0; s <= T; s++) begin
        sb[s] <= '0;
        ss[s] <= '0;
        sr[s] <= 1'b0;
      end
      vld       <= '0;
      b_q       <= '0;
      b_scale   <= '0;
      b_relu    <= 1'b0;
      b_vld     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < TAPS; k++) node[NPAD+k] <= ACC_W'(prod[k]);
      for (int unsigned i = 1; i < NPAD; i++) node[i] <= node[2*i] + node[2*i+1];
      vld   <= {vld[T-1:0], in_valid};
      sb[0] <= in_bias;
      ss[0] <= in_scale;
      sr[0] <= in_relu;
      for (int unsigned s = 1; s <= T; s++) begin
        sb[s] <= sb[s-1];
        ss[s] <= ss[s-1];
        sr[s] <= sr[s-1];
      end
      b_q       <= bsum;
      b_scale   <= ss[T];
      b_relu    <= sr[T];
      b_vld     <= vld[T];
      out_valid <= b_vld;
      out_data  <= rq_q;
      out_sat   <= rq_sat;
    end
  end

endmodule

// File: tb/tb_conv_quant_pe.sv
// Scoreboard bench for conv_quant_pe: directed numeric cases, a stalled random
// stream, and a mid-flight reset; expected values come from a behavioural model.
module tb_conv_quant_pe;

  localparam int unsigned TAPS    = 9;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned WGT_W   = 8;
  localparam int unsigned BIAS_W  = 24;
  localparam int unsigned SCALE_W = 32;
  localparam int unsigned SHIFT   = 32;
  localparam int unsigned OUT_W   = 8;
  localparam int          LAT     = 7;

  typedef struct {
    logic [OUT_W-1:0] q;
    logic             sat;
    int               cyc;
    bit               lat;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [TAPS*DATA_W-1:0] in_data;
  logic [TAPS*WGT_W-1:0]  in_wgt;
  logic [BIAS_W-1:0]      in_bias;
  logic [SCALE_W-1:0]     in_scale;
  logic                   in_relu;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_sat;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b1;
  exp_t sb_q[$];

  conv_quant_pe #(
    .TAPS    (TAPS),
    .DATA_W  (DATA_W),
    .WGT_W   (WGT_W),
    .BIAS_W  (BIAS_W),
    .SCALE_W (SCALE_W),
    .SHIFT   (SHIFT),
    .OUT_W   (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_wgt    (in_wgt),
    .in_bias   (in_bias),
    .in_scale  (in_scale),
    .in_relu   (in_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model(input logic [TAPS*DATA_W-1:0] dat,
                                input logic [TAPS*WGT_W-1:0] wg,
                                input logic [BIAS_W-1:0] bias,
                                input logic [SCALE_W-1:0] scale,
                                input logic relu,
                                output logic [OUT_W-1:0] q,
                                output logic sat);
    longint acc, b, m, r, hi, lo;
    logic [DATA_W-1:0] d;
    logic [WGT_W-1:0]  w;
    acc = 0;
    for (int k = 0; k < int'(TAPS); k++) begin
      d = dat[k*DATA_W +: DATA_W];
      w = wg[k*WGT_W +: WGT_W];
      acc += longint'(d) * longint'($signed(w));
    end
    b = acc + longint'($signed(bias));
    if (relu && b < 0) b = 0;
    m = b * longint'(scale);
    r = (m + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    hi = relu ? 255 : 127;
    lo = relu ? 0 : -128;
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    q = r[OUT_W-1:0];
  endfunction

  // Scoreboard: sample between edges so handshakes are stable for the next edge.
  always @(negedge clk) begin
    exp_t it;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("out_data", out_data, sb_q[0].q);
          chk("out_sat", out_sat, sb_q[0].sat);
          if (!out_ready) chk("stall_in_ready", in_ready, 0);
          else begin
            if (sb_q[0].lat) chk("latency", cyc - sb_q[0].cyc, LAT);
            void'(sb_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        model(in_data, in_wgt, in_bias, in_scale, in_relu, it.q, it.sat);
        it.cyc = cyc;
        it.lat = lat_mode;
        sb_q.push_back(it);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [TAPS*DATA_W-1:0] d, input logic [TAPS*WGT_W-1:0] w,
                      input logic [BIAS_W-1:0] bias, input logic [SCALE_W-1:0] scale,
                      input logic relu);
    bit done;
    in_data  = d;
    in_wgt   = w;
    in_bias  = bias;
    in_scale = scale;
    in_relu  = relu;
    in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_fill(input logic [DATA_W-1:0] dv, input logic [WGT_W-1:0] wv,
                           input logic [BIAS_W-1:0] bias, input logic relu);
    logic [TAPS*DATA_W-1:0] d;
    logic [TAPS*WGT_W-1:0]  w;
    for (int k = 0; k < int'(TAPS); k++) begin
      d[k*DATA_W +: DATA_W] = dv;
      w[k*WGT_W +: WGT_W]   = wv;
    end
    send(d, w, bias, 32'h8000_0000, relu);
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) step();
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    in_wgt    = '0;
    in_bias   = '0;
    in_scale  = '0;
    in_relu   = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    step();

    send_fill(8'd10, 8'd2, 24'd20, 1'b1);         drain();
    send_fill(8'd1, 8'd1, 24'd0, 1'b1);           drain();
    send_fill(8'd100, 8'hFF, 24'd0, 1'b1);        drain();
    send_fill(8'd100, 8'hFF, 24'd0, 1'b0);        drain();
    send_fill(8'd255, 8'd127, 24'd0, 1'b1);       drain();
    send_fill(8'd255, 8'h80, 24'd0, 1'b0);        drain();

    lat_mode = 1'b0;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          logic [TAPS*DATA_W-1:0] d;
          logic [TAPS*WGT_W-1:0]  w;
          int                     bias;
          repeat ($urandom_range(0, 2)) step();
          for (int k = 0; k < int'(TAPS); k++) begin
            d[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
            w[k*WGT_W +: WGT_W]   = WGT_W'($urandom_range(0, 255));
          end
          bias = int'($urandom_range(0, 4000)) - 2000;
          send(d, w, BIAS_W'(bias), SCALE_W'($urandom_range(0, 32'h0400_0000)),
               1'($urandom_range(0, 1)));
        end
      end
      begin
        repeat (8) step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
      end
    join
    drain();
    lat_mode = 1'b1;

    send_fill(8'd3, 8'd4, 24'd0, 1'b0);
    send_fill(8'd5, 8'd6, 24'd7, 1'b1);
    send_fill(8'd7, 8'hFE, 24'd0, 1'b0);
    send_fill(8'd9, 8'd9, 24'd1, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready_after", in_ready, 1);
    repeat (12) step();
    send_fill(8'd10, 8'd2, 24'd20, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_quant_pe.md
# conv_quant_pe

Parametrised, pipelined convolution processing element: TAPS-wide unsigned-data × signed-weight dot product, balanced adder tree, bias add, optional ReLU, fixed-point requantisation with round-half-up and saturation, all behind a valid/ready stream interface with backpressure. It is the next-generation replacement for the fixed 9-tap conv + quantizer pair and sits between the window/line-buffer front end and the max-pool/output writer.

## Interface
- TAPS, 9, kernel taps per dot product (≥2)
- DATA_W, 8, unsigned activation width
- WGT_W, 8, signed weight width
- BIAS_W, 24, signed bias width
- SCALE_W, 32, unsigned scale width
- SHIFT, 32, fractional bits of scale (≥1)
- OUT_W, 8, output width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  PE accepts beat this cycle
- in_data  in  TAPS*DATA_W  activations, tap k at [k*DATA_W +: DATA_W]
- in_wgt  in  TAPS*WGT_W  weights, tap k at [k*WGT_W +: WGT_W]
- in_bias  in  BIAS_W  signed bias for this beat
- in_scale  in  SCALE_W  requant multiplier for this beat
- in_relu  in  1  1: ReLU + unsigned output; 0: signed output
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  quantised result (unsigned if relu, else two's complement)
- out_sat  out  1  result was clipped by saturation

## Operation
- Beat accepted when in_valid && in_ready; bias, scale, relu travel with the beat (per-beat, no shadow registers).
- Product stage: p_k = $signed({1'b0,data_k}) * $signed(wgt_k), width DATA_W+WGT_W+1.
- Tree: T = clog2(TAPS) registered adder levels; taps padded with zero to 2^T; ACC_W = DATA_W+WGT_W+1+T, sign-extended at each level, no overflow possible.
- Bias stage: b = acc + sext(bias), width max(ACC_W,BIAS_W)+1; if relu and b<0 then b=0.
- Requant stage: m = b * $signed({1'b0,scale}); r = (m + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf).
- Saturate: relu → clip r to [0, 2^OUT_W-1]; !relu → clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 iff clipped.
- Each stage carries a valid bit; bubbles propagate, not collapsed. Order strictly preserved.

## Timing
- Latency L = T+3 cycles accept→out_valid with no stall (TAPS=9: L=7). Throughput one beat/cycle.
- Global enable en = !out_valid || out_ready; all stage registers and valids advance only when en.
- in_ready = en && rst_n (combinational from out_valid/out_ready; no combinational in_valid→in_ready path).
- out_valid held with out_data/out_sat stable until out_ready; simultaneous accept at input and output in the same cycle allowed.
- Reset (rst_n low at clk edge): all valid bits 0, out_valid 0, out_data 0, out_sat 0; data registers zeroed. Reset mid-operation drops all in-flight beats; in_ready 0 while rst_n low, 1 on first cycle after release.
- out_ready high with out_valid low: no effect.

## Structure
- Package conv_pkg: clog2 function, ACC_W/BIAS-stage/product width localparam formulas, sat-range helpers shared with maxpool/quantiser consumers.
- Sub-module requant_sat: bias-stage output → round, shift, saturate, sat flag (combinational core, registered by parent); reused by future depthwise PE.
- Adder tree as generate loop inside the parent.

## Test plan
- Default params, data all 10, weights all 2, bias 20, scale 0x8000_0000, relu=1 → out_data 100, out_sat 0, out_valid exactly 7 cycles after accept.
- Data all 1, weights all 1, bias 0, scale 0x8000_0000, relu=1 → 4.5 rounds to 5.
- Data all 100, weights all -1, bias 0, scale 0x8000_0000: relu=1 → 0, sat 0; relu=0 → -450 → 0x80 (-128), sat 1.
- Data all 255, weights all 127, bias 0, scale 0x8000_0000, relu=1 → 255, sat 1; weights -128, relu=0 → -128, sat 1.
- Stream 20 beats with random valid gaps, out_ready low 5 cycles mid-stream → no loss/duplication, order preserved, outputs stable while stalled, in_ready low while stalled and output full.
- Assert rst_n low for 1 cycle with 4 beats in flight → out_valid 0, out_data 0 next cycle, no stale beat emerges; new beat afterward returns correct result after L.
